// File: rtl/ascii_text_injector_pkg.sv
// Shared definitions for the Apple-I text injector: FSM encodings, ASCII
// codes and PIA register selects.
package apple1_pkg;

    typedef logic [2:0] inj_state_t;

    localparam inj_state_t ST_IDLE      = 3'd0;
    localparam inj_state_t ST_LOAD      = 3'd1;
    localparam inj_state_t ST_FETCH     = 3'd2;
    localparam inj_state_t ST_PRESENT   = 3'd3;
    localparam inj_state_t ST_WAIT_READ = 3'd4;
    localparam inj_state_t ST_PACE      = 3'd5;

    localparam logic [7:0] ASCII_NUL = 8'h00;
    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam logic [7:0] ASCII_CR  = 8'h0D;

    localparam logic RX_DATA   = 1'b0;
    localparam logic RX_STATUS = 1'b1;

    function automatic logic [7:0] fold_upper(input logic [7:0] b);
        return (b >= 8'h61 && b <= 8'h7A) ? (b - 8'h20) : b;
    endfunction

endpackage

// File: rtl/ascii_text_injector_if.sv
// Download bus, live keyboard and PIA read port of the text injector,
// bundled so the injector and its driver share one connection.
interface ascii_text_injector_if;

    logic        ioctl_download;
    logic        ioctl_wr;
    logic [15:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        key_strobe;
    logic [7:0]  key_ascii;
    logic        abort;
    logic        cs;
    logic        address;
    logic [7:0]  dout;
    logic        busy;
    logic        overflow;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        output key_strobe, key_ascii, abort, cs, address,
        input  dout, busy, overflow
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        input  key_strobe, key_ascii, abort, cs, address,
        output dout, busy, overflow
    );

endinterface

// File: rtl/ascii_text_injector_text_buffer_ram.sv
// Text buffer: 2**ADDR_W x 8 simple dual-port RAM, one write port and one
// registered read port (1-cycle latency), written for block-RAM inference.
module text_buffer_ram #(
    parameter int ADDR_W = 12
) (
    input  logic              clk25,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    logic [7:0] mem [2**ADDR_W];

    always_ff @(posedge clk25) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/ascii_text_injector.sv
// Captures a downloaded text file and replays it into the PIA keyboard port,
// one paced character per CPU data read, with a live-keyboard passthrough.
module ascii_text_injector
    import apple1_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int PACE_DIV   = 4000,
    parameter bit UPCASE     = 1'b1,
    parameter bit CRLF_MERGE = 1'b1
) (
    input  logic                  clk25,
    input  logic                  rst,
    ascii_text_injector_if.slave  bus
);

    localparam int PACE_W = (PACE_DIV > 1) ? $clog2(PACE_DIV) : 1;

    inj_state_t        state;
    logic [7:0]        chr;
    logic              rdy;
    logic [ADDR_W-1:0] last;
    logic [ADDR_W:0]   rd_ptr;
    logic [PACE_W-1:0] pace_cnt;
    logic              loaded;
    logic              overflow_r;
    logic              fetch_vld;
    logic              prev_cr;
    logic [7:0]        dout_r;
    logic [7:0]        rd_data;

    logic busy_w;
    logic addr_fits;
    logic ram_we;
    logic ptr_past_end;
    logic byte_skip;

    function automatic logic [7:0] xlat(input logic [7:0] b);
        logic [7:0] r;
        r = (b == ASCII_LF) ? ASCII_CR : b;
        if (UPCASE) begin
            r = fold_upper(r);
        end
        return r;
    endfunction

    assign busy_w       = (state != ST_IDLE) && (state != ST_LOAD);
    assign addr_fits    = (bus.ioctl_addr >> ADDR_W) == 16'd0;
    assign ram_we       = (state == ST_LOAD) && bus.ioctl_download && bus.ioctl_wr && addr_fits;
    assign ptr_past_end = rd_ptr > {1'b0, last};
    assign byte_skip    = (rd_data == ASCII_NUL) ||
                          (CRLF_MERGE && prev_cr && (rd_data == ASCII_LF));

    text_buffer_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk25   (clk25),
        .we      (ram_we),
        .wr_addr (bus.ioctl_addr[ADDR_W-1:0]),
        .wr_data (bus.ioctl_dout),
        .rd_addr (rd_ptr[ADDR_W-1:0]),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk25) begin
        if (rst) begin
            state      <= ST_IDLE;
            chr        <= 8'h00;
            rdy        <= 1'b0;
            last       <= '0;
            rd_ptr     <= '0;
            pace_cnt   <= '0;
            loaded     <= 1'b0;
            overflow_r <= 1'b0;
            fetch_vld  <= 1'b0;
            prev_cr    <= 1'b0;
            dout_r     <= 8'h00;
        end else begin
            // CPU port first so that a set from the FSM below wins the same cycle
            if (bus.cs) begin
                if (bus.address == RX_STATUS) begin
                    dout_r <= {rdy, 7'b0};
                end else begin
                    dout_r <= {1'b1 | chr[7], chr[6:0]};
                    rdy    <= 1'b0;
                end
            end

            if (busy_w && bus.ioctl_download) begin
                state      <= ST_LOAD;
                rdy        <= 1'b0;
                overflow_r <= 1'b0;
                loaded     <= 1'b0;
                last       <= '0;
            end else if (busy_w && bus.abort) begin
                state <= ST_IDLE;
                rdy   <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.ioctl_download) begin
                            state      <= ST_LOAD;
                            overflow_r <= 1'b0;
                            loaded     <= 1'b0;
                            last       <= '0;
                        end else if (bus.key_strobe) begin
                            chr <= bus.key_ascii;
                            rdy <= 1'b1;
                        end
                    end
                    ST_LOAD: begin
                        if (bus.ioctl_download) begin
                            if (bus.ioctl_wr) begin
                                if (addr_fits) begin
                                    loaded <= 1'b1;
                                    if (bus.ioctl_addr[ADDR_W-1:0] > last) begin
                                        last <= bus.ioctl_addr[ADDR_W-1:0];
                                    end
                                end else begin
                                    overflow_r <= 1'b1;
                                end
                            end
                        end else if (loaded) begin
                            state     <= ST_FETCH;
                            rd_ptr    <= '0;
                            fetch_vld <= 1'b0;
                            prev_cr   <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                    ST_FETCH: begin
                        // rd_data is valid once rd_ptr has been stable for one edge
                        if (ptr_past_end) begin
                            state <= ST_IDLE;
                        end else if (!fetch_vld) begin
                            fetch_vld <= 1'b1;
                        end else if (byte_skip) begin
                            rd_ptr    <= rd_ptr + {{ADDR_W{1'b0}}, 1'b1};
                            fetch_vld <= 1'b0;
                            prev_cr   <= 1'b0;
                        end else begin
                            state <= ST_PRESENT;
                        end
                    end
                    ST_PRESENT: begin
                        chr     <= xlat(rd_data);
                        rdy     <= 1'b1;
                        prev_cr <= (rd_data == ASCII_CR);
                        state   <= ST_WAIT_READ;
                    end
                    ST_WAIT_READ: begin
                        if (bus.cs && (bus.address == RX_DATA)) begin
                            rd_ptr   <= rd_ptr + {{ADDR_W{1'b0}}, 1'b1};
                            pace_cnt <= PACE_W'(PACE_DIV - 1);
                            state    <= ST_PACE;
                        end
                    end
                    ST_PACE: begin
                        // rd_ptr is already stable, so the next byte is ready on exit
                        if (pace_cnt == '0) begin
                            if (ptr_past_end) begin
                                state <= ST_IDLE;
                            end else begin
                                state     <= ST_FETCH;
                                fetch_vld <= 1'b1;
                            end
                        end else begin
                            pace_cnt <= pace_cnt - PACE_W'(1);
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.dout     = dout_r;
    assign bus.busy     = busy_w;
    assign bus.overflow = overflow_r;

endmodule

// File: doc/ascii_text_injector.md
Name: ascii_text_injector

Overview:
Parametrised successor to the Apple-I text-load path. Captures a text file streamed over the ioctl download bus into an internal buffer, then replays it into the PIA keyboard port at a paced rate, one character per CPU read. Adds configurable depth and pacing, a real read/pace handshake, optional LF/CRLF and case translation, a live-keyboard passthrough channel, abort, and overflow reporting.

Parameters:
ADDR_W, 12, buffer address width; depth = 2**ADDR_W bytes
PACE_DIV, 4000, clk25 cycles between a CPU read of a character and presentation of the next
UPCASE, 1, fold 'a'..'z' to 'A'..'Z' on replay
CRLF_MERGE, 1, drop a 0x0A that directly follows a 0x0D

Ports:
clk25  in  1  system clock (25 MHz)
rst  in  1  reset: synchronous, active-high
ioctl_download  in  1  download window active
ioctl_wr  in  1  byte strobe, valid while ioctl_download
ioctl_addr  in  16  byte address within file
ioctl_dout  in  8  byte data
key_strobe  in  1  live keyboard character valid (one cycle)
key_ascii  in  8  live keyboard character
abort  in  1  cancel replay (one cycle)
cs  in  1  PIA chip select, one-cycle pulse per access
address  in  1  0 = RX data, 1 = RX status
dout  out  8  read data
busy  out  1  replay in progress
overflow  out  1  file exceeded buffer; sticky until next download starts

Behaviour:
- Reset: state IDLE; dout = 0x00, busy = 0, overflow = 0, rdy = 0, char register = 0x00, last = 0, rd_ptr = 0, pace counter = 0, loaded = 0.
- States: IDLE, LOAD, FETCH, PRESENT, WAIT_READ, PACE.
- IDLE -> LOAD on ioctl_download = 1; clears overflow, loaded, last.
- LOAD: each ioctl_wr with ioctl_addr < 2**ADDR_W writes mem[ioctl_addr[ADDR_W-1:0]], sets loaded, and sets last = max(last, ioctl_addr). Any address >= 2**ADDR_W sets overflow; the byte is discarded. Overflowed files still replay the bytes that fit.
- LOAD -> FETCH when ioctl_download falls and loaded = 1; rd_ptr = 0. Falls with loaded = 0 -> IDLE.
- FETCH: synchronous RAM read, 1-cycle latency. Translation:
  - 0x00 is skipped.
  - 0x0A following a 0x0D is skipped when CRLF_MERGE = 1; otherwise 0x0A -> 0x0D.
  - UPCASE folds 'a'..'z' to 'A'..'Z'.
  - A skipped byte advances rd_ptr and stays in FETCH.
  - After rd_ptr passes last -> IDLE.
- PRESENT: load char register, set rdy, -> WAIT_READ.
- WAIT_READ: cs = 1 with address = 0 clears rdy, advances rd_ptr, -> PACE.
- PACE: counts PACE_DIV-1 down to 0, then -> FETCH; if rd_ptr > last, -> IDLE instead.
- busy = 1 in FETCH, PRESENT, WAIT_READ, PACE.
- CPU reads are registered, 1-cycle latency:
  - address 0: dout = {1'b1, char[6:0]}, clears rdy.
  - address 1: dout = {rdy, 7'b0}.
  - dout holds its value between reads.
- Live keyboard: key_strobe while busy = 0 and not in LOAD loads char = key_ascii and sets rdy. An unread live char is overwritten by the next one. key_strobe during busy or LOAD is dropped.
- abort while busy: -> IDLE, rdy cleared, buffer contents kept. abort in IDLE or LOAD is ignored.
- ioctl_download rising during replay: replay is abandoned, rdy cleared, -> LOAD.
- Simultaneous read clear and PRESENT set cannot occur: PRESENT is only reachable from FETCH.
- rst mid-operation returns everything to reset values; buffer RAM contents are undefined and unused.

Decomposition:
- Shared package apple1_pkg:
  - state enum for the injector
  - ASCII constants: CR = 0x0D, LF = 0x0A, NUL = 0x00
  - PIA register select constants: RX_DATA = 0, RX_STATUS = 1
- One sub-module, text_buffer_ram: single-port write / single-port read synchronous RAM, 2**ADDR_W x 8, 1-cycle read latency, inferable as block RAM.

Test Plan:
- Download "AB\n" (0x41, 0x42, 0x0A); poll status and read after each rdy -> data reads 0xC1, 0xC2, 0x8D. The gap from a read to the next rdy is PACE_DIV+2 cycles (±1). busy falls after the third read.
- Download "x\r\ny" with UPCASE = 1, CRLF_MERGE = 1 -> reads 0xD8, 0x8D, 0xD9; exactly three characters.
- ADDR_W = 4, download 20 bytes -> overflow = 1, first 16 bytes replayed. overflow clears at the next download start.
- Assert abort after the 2nd character of 10 -> busy = 0 and status = 0x00 next cycle. A later key_strobe 0x52 gives status 0x80 and data 0xD2.
- key_strobe 0x41 while busy -> dropped: the replayed character sequence is unchanged.
- Assert rst during PACE -> next cycle dout = 0x00, busy = 0, status read = 0x00. A new download replays from byte 0.
